// File: rtl/arb_pkg.sv
// Shared arbiter definitions.
//   arb_mode_e : runtime arbitration policy select
//   next_rr()  : first set index of a request vector at or after a pointer,
//                scanning modulo n; returns -1 when the vector is empty.
package arb_pkg;

  typedef enum logic {ARB_FCFS, ARB_RR} arb_mode_e;

  // Widest request vector next_rr() accepts; callers zero-extend into it.
  localparam int ARB_MAXN = 64;
  localparam int ARB_PW   = 6;

  function automatic int next_rr(input int ptr, input logic [ARB_MAXN-1:0] vec, input int n);
    next_rr = -1;
    // Walk offsets high to low so the smallest offset from ptr wins.
    for (int k = n - 1; k >= 0; k--)
      if (vec[ARB_PW'((ptr + k) % n)]) next_rr = (ptr + k) % n;
  endfunction

endpackage

// File: rtl/arb_order_queue.sv
// Arrival-order queue of requester IDs (shift-compacting, head at slot 0).
//   clk, reset : clock, async active-high reset (queue empty)
//   drop       : per-ID mask; matching entries are removed (requester withdrew)
//   enq        : per-ID mask of new arrivals, appended in round-robin order from enq_ptr
//   tail_vld/id: one extra ID appended after the arrivals (preempted holder)
//   rm         : per-ID mask removed after the appends (the winner being dequeued)
//   head_vld/id: head of the queue after drops and appends, before rm
// An ID is present at most once, so NUM_REQUESTS slots never overflow.
module arb_order_queue
  import arb_pkg::*;
#(
  parameter int NUM_REQUESTS = 4,
  parameter int IDW          = $clog2(NUM_REQUESTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQUESTS-1:0] drop,
  input  logic [NUM_REQUESTS-1:0] enq,
  input  logic [IDW-1:0]          enq_ptr,
  input  logic                    tail_vld,
  input  logic [IDW-1:0]          tail_id,
  input  logic [NUM_REQUESTS-1:0] rm,
  output logic                    head_vld,
  output logic [IDW-1:0]          head_id
);
  localparam int N = NUM_REQUESTS;

  logic [N-1:0]          q_vld, a_vld, b_vld;
  logic [N-1:0][IDW-1:0] q_id, a_id, b_id;

  // Stage A: compact out withdrawn entries, then append arrivals and the tail ID.
  always_comb begin : stage_a
    int n;
    int j;
    a_vld = '0;
    a_id  = '0;
    n     = 0;
    j     = 0;
    for (int i = 0; i < N; i++)
      if (q_vld[i] && !drop[q_id[i]] && n < N) begin
        a_vld[IDW'(n)] = 1'b1;
        a_id[IDW'(n)]  = q_id[i];
        n++;
      end
    for (int k = 0; k < N; k++) begin
      j = (int'(enq_ptr) + k) % N;
      if (enq[IDW'(j)] && n < N) begin
        a_vld[IDW'(n)] = 1'b1;
        a_id[IDW'(n)]  = IDW'(j);
        n++;
      end
    end
    if (tail_vld && n < N) begin
      a_vld[IDW'(n)] = 1'b1;
      a_id[IDW'(n)]  = tail_id;
    end
  end

  // Stage B: remove the dequeued winner and close the gap.
  always_comb begin : stage_b
    int n;
    b_vld = '0;
    b_id  = '0;
    n     = 0;
    for (int i = 0; i < N; i++)
      if (a_vld[i] && !rm[a_id[i]] && n < N) begin
        b_vld[IDW'(n)] = 1'b1;
        b_id[IDW'(n)]  = a_id[i];
        n++;
      end
  end

  assign head_vld = a_vld[0];
  assign head_id  = a_id[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_vld <= '0;
      q_id  <= '0;
    end else begin
      q_vld <= b_vld;
      q_id  <= b_id;
    end
  end

endmodule

// File: rtl/fcfs_rr_multimode_arbiter.sv
// N-way arbiter with runtime FCFS / round-robin policy, grant hold until
// release, bounded hold time with forced preemption, zero-bubble handover.
//   clk, reset  : clock, async active-high reset
//   mode        : 0 = FCFS (arrival order), 1 = round-robin from rr_ptr
//   req         : level requests
//   grant       : registered one-hot grant (or zero)
//   grant_valid : OR of grant
//   grant_id    : holder index, 0 when idle
//   preempt     : high in the first cycle of a grant that followed a forced release
module fcfs_rr_multimode_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQUESTS = 4,
  parameter int MAX_HOLD     = 16,
  parameter int IDW          = $clog2(NUM_REQUESTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [NUM_REQUESTS-1:0] req,
  output logic [NUM_REQUESTS-1:0] grant,
  output logic                    grant_valid,
  output logic [IDW-1:0]          grant_id,
  output logic                    preempt
);
  localparam int N        = NUM_REQUESTS;
  localparam int HCW      = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  logic [N-1:0]   req_q, arrive, cand, win_mask;
  logic [IDW-1:0] rr_ptr, win_id, q_head_id;
  logic [HCW-1:0] hold_cnt;
  logic           hold_req, contested, timeout, release_h, arb, win_vld, q_head_vld;
  int             rr_w;

  assign grant_valid = |grant;

  always_comb begin
    arrive    = req & ~req_q;
    hold_req  = |(req & grant);
    contested = |(req & ~grant);
    timeout   = (MAX_HOLD > 0) && grant_valid && hold_req && contested &&
                (hold_cnt == HCW'(HOLD_LIM));
    release_h = grant_valid && (!hold_req || timeout);
    arb       = !grant_valid || release_h;
    // The holder never competes in the arbitration at which it is released.
    cand      = req & ~grant;
    rr_w      = next_rr(int'(rr_ptr), ARB_MAXN'(cand), N);
    win_vld   = 1'b0;
    win_id    = '0;
    if (arb) begin
      if (arb_mode_e'(mode) == ARB_RR) begin
        if (rr_w >= 0) begin
          win_vld = 1'b1;
          win_id  = IDW'(rr_w);
        end
      end else if (q_head_vld) begin
        // Queue head already includes this edge's arrivals, which covers the bypass case.
        win_vld = 1'b1;
        win_id  = q_head_id;
      end
    end
    win_mask = win_vld ? (N'(1) << win_id) : '0;
  end

  // Queue is maintained in both modes; the winner is dequeued by ID either way.
  arb_order_queue #(.NUM_REQUESTS(N), .IDW(IDW)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .drop     (~req),
    .enq      (arrive),
    .enq_ptr  (rr_ptr),
    .tail_vld (timeout),
    .tail_id  (grant_id),
    .rm       (win_mask),
    .head_vld (q_head_vld),
    .head_id  (q_head_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q    <= '0;
      grant    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      req_q <= req;
      if (arb) begin
        grant    <= win_mask;
        grant_id <= win_id;
        hold_cnt <= '0;
        preempt  <= timeout;
        if (win_vld)
          rr_ptr <= (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
      end else begin
        preempt <= 1'b0;
        // Uncontested holder at the limit keeps the grant; the count restarts.
        if (MAX_HOLD > 0 && hold_cnt == HCW'(HOLD_LIM))
          hold_cnt <= '0;
        else
          hold_cnt <= hold_cnt + HCW'(1);
      end
    end
  end

endmodule

// File: doc/fcfs_rr_multimode_arbiter.md
# fcfs_rr_multimode_arbiter

Parametrised N-way arbiter with runtime selection between first-come-first-served and round-robin policy. It is the successor to the fixed FCFS arbiter. It adds arrival-order queuing with round-robin tie-break, grant hold until the requester releases, a bounded hold time with forced preemption, and zero-bubble handover. It sits between the requesting masters and a single shared resource.

## Interface
- NUM_REQUESTS, 4, number of requesters (≥2)
- MAX_HOLD, 16, maximum consecutive grant cycles before forced release; 0 disables the limit
- IDW, $clog2(NUM_REQUESTS), derived width of the requester index
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- mode  input  1  0 = FCFS, 1 = round-robin
- req  input  NUM_REQUESTS  level request per requester; held high while the resource is wanted
- grant  output  NUM_REQUESTS  registered one-hot grant, or all-zero
- grant_valid  output  1  OR of grant
- grant_id  output  IDW  index of holder; 0 when grant_valid = 0
- preempt  output  1  one-cycle pulse on the cycle after a forced release

## Operation
- Arrival is detected on the rising edge of req[i] (req & ~req_q); req_q resets to 0.
- Queue: ordered FIFO of requester IDs, depth NUM_REQUESTS. Each ID appears at most once, so the queue cannot overflow.
- Arrivals in the same cycle are enqueued in round-robin order, starting at rr_ptr and wrapping modulo NUM_REQUESTS.
- If a queued requester drops req before it is granted, its entry is removed and later entries shift toward the head.
- rr_ptr = (last granted ID + 1) mod NUM_REQUESTS; it is updated on every new grant.
- Arbitration happens at every edge where there is no holder or the holder is released.
  - FCFS: the winner is the queue head. If the queue is empty, the winner is the first new arrival in round-robin order (bypass).
  - RR: the winner is the first asserted req at or after rr_ptr.
  - The released holder is excluded from the arbitration at which it is released.
- Release: the holder is released when req[holder] is sampled low, or on timeout.
- Timeout: the hold counter increments while a grant is held. When it reaches MAX_HOLD − 1, the holder still requests, and another requester is pending:
  - the grant is forced off;
  - the holder is re-enqueued at the tail;
  - preempt pulses.
- If no other requester is pending at MAX_HOLD − 1, the holder keeps the grant and the counter restarts at 0.
- mode is sampled only at arbitration edges. The queue is maintained in both modes, so a mode switch takes effect at the next decision without loss of order.
- The winner is dequeued in both modes.

## Timing
- Reset values: grant = 0, grant_valid = 0, grant_id = 0, preempt = 0, queue empty, rr_ptr = 0, hold counter = 0.
- Reset asserted mid-grant clears all state immediately, asynchronously.
- Requests already high when reset deasserts are treated as arrivals at the first edge.
- Latency, idle arbiter: req[i] first sampled high at edge t → grant[i] high after edge t (one cycle after assertion).
- Handover: holder's req sampled low at edge t → grant moves to the next winner at edge t, with no idle cycle. If nothing is pending, grant = 0 after t.
- Grant is never issued to a requester whose req is low at the deciding edge.
- Timeout: with MAX_HOLD = M, a contested holder keeps the grant for exactly M cycles. preempt is high in the first cycle of the new grant.

## Structure
- Shared package arb_pkg:
  - typedef enum logic {ARB_FCFS, ARB_RR} arb_mode_e;
  - function next_rr(ptr, vec) returning the first set index at or after ptr.
- Sub-module arb_order_queue, parametrised by NUM_REQUESTS: shift-compacting ID FIFO with multi-enqueue, remove-by-ID and pop.
- Top level holds the edge detect, policy mux, holder, hold counter and rr_ptr.

## Test plan
- Reset release with req = 4'b1010 → first grant 4'b0010 at the first edge. After req[1] drops, grant = 4'b1000 at the next edge.
- FCFS order: req[3] rises at cycle 2, req[0] at cycle 3, req[2] at cycle 4, each held 3 cycles → grants in order 3, 0, 2 with zero-bubble handover.
- RR mode: all four req held permanently, MAX_HOLD = 4 → grant rotates 0→1→2→3→0, each grant lasting 4 cycles, with preempt pulsing at each switch.
- Uncontested holder: only req[2] high for 40 cycles with MAX_HOLD = 16 → grant 4'b0100 continuous and preempt never asserted.
- Queued withdrawal: queue [1, 3, 0], req[3] drops while 1 holds → after 1 releases, grant = 4'b0001 and ID 3 is never granted.
- Async reset asserted mid-grant (cycle 7.5) → grant = 0 and grant_valid = 0 before the next edge, and the queue is empty after reset release.
